// File: rtl/iiitb_pudc_pkg.sv
// Shared constants and helpers for the iiitb_pudc up/down modulo counter.
package iiitb_pudc_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // All-ones value for a given width (widths up to 32 bits).
  function automatic int unsigned pudc_default_max(input int width);
    longint unsigned full;
    full = (64'd1 << width) - 64'd1;
    return full[31:0];
  endfunction

endpackage

// File: rtl/iiitb_pudc_next.sv
// Next-count and boundary detect for iiitb_pudc; IIITB_PUDC_SAT_EN selects saturation instead of wrap.
module iiitb_pudc_next
  import iiitb_pudc_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter int unsigned MAX_COUNT = pudc_default_max(WIDTH)
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] next_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  // Boundaries are MAX_COUNT and zero, never the raw WIDTH-bit rollover.
  always_comb begin
    next_o = count_i;
    tc_o   = 1'b0;
    if (up_i == DIR_UP) begin
      if (count_i == MAX_V) begin
`ifdef IIITB_PUDC_SAT_EN
        next_o = MAX_V;
`else
        next_o = '0;
`endif
        tc_o = 1'b1;
      end else begin
        next_o = count_i + ONE_V;
      end
    end else begin
      if (count_i == '0) begin
`ifdef IIITB_PUDC_SAT_EN
        next_o = '0;
`else
        next_o = MAX_V;
`endif
        tc_o = 1'b1;
      end else begin
        next_o = count_i - ONE_V;
      end
    end
  end

endmodule

// File: rtl/iiitb_pudc.sv
// Parametrised up/down modulo counter with enable, clamped load and registered terminal count.
// Build option IIITB_PUDC_SAT_EN switches boundary behaviour from wrap to saturate.
module iiitb_pudc
  import iiitb_pudc_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter int unsigned MAX_COUNT = pudc_default_max(WIDTH)
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             UpOrDown,
  output logic [WIDTH-1:0] Count,
  output logic             Tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("iiitb_pudc: WIDTH must be in 1..32");
  end
  if (MAX_COUNT < 1 || MAX_COUNT > pudc_default_max(WIDTH)) begin : g_bad_max
    $error("iiitb_pudc: MAX_COUNT must be in 1..2**WIDTH-1");
  end

  logic [WIDTH-1:0] Count_q, Count_d;
  logic             Tc_q, Tc_d;
  logic [WIDTH-1:0] step_cnt;
  logic             step_tc;
  logic [WIDTH-1:0] load_cnt;

  iiitb_pudc_next #(
    .WIDTH    (WIDTH),
    .MAX_COUNT(MAX_COUNT)
  ) u_next (
    .count_i(Count_q),
    .up_i   (UpOrDown),
    .next_o (step_cnt),
    .tc_o   (step_tc)
  );

  // Out-of-range load values clamp so Count never exceeds MAX_COUNT.
  assign load_cnt = (LoadVal > MAX_V) ? MAX_V : LoadVal;

  always_comb begin
    Count_d = Count_q;
    Tc_d    = 1'b0;
    if (Load) begin
      Count_d = load_cnt;
    end else if (En) begin
      Count_d = step_cnt;
      Tc_d    = step_tc;
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      Count_q <= '0;
      Tc_q    <= 1'b0;
    end else begin
      Count_q <= Count_d;
      Tc_q    <= Tc_d;
    end
  end

  assign Count = Count_q;
  assign Tc    = Tc_q;

endmodule

// File: tb/tb_iiitb_pudc.sv
// Bench for iiitb_pudc (WIDTH=4, MAX_COUNT=9): directed vector table plus randomized model check.
module tb_iiitb_pudc;

  localparam int W   = 4;
  localparam int MAX = 9;

  logic         Clk = 1'b0;
  logic         reset;
  logic         En;
  logic         Load;
  logic [W-1:0] LoadVal;
  logic         UpOrDown;
  logic [W-1:0] Count;
  logic         Tc;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_cnt = 0;
  int m_tc  = 0;

  typedef struct {
    bit      rst_n;
    bit      ld;
    int      lv;
    bit      en;
    bit      ud;
    int      exp_cnt;
    int      exp_tc;
    string   name;
  } vec_t;

  vec_t vecs[$];

  iiitb_pudc #(.WIDTH(W), .MAX_COUNT(MAX)) dut (
    .Clk     (Clk),
    .reset   (reset),
    .En      (En),
    .Load    (Load),
    .LoadVal (LoadVal),
    .UpOrDown(UpOrDown),
    .Count   (Count),
    .Tc      (Tc)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input bit ld, input int lv, input bit en, input bit ud,
                     input int ec, input int et, input string nm);
    vec_t v;
    v.rst_n = r; v.ld = ld; v.lv = lv; v.en = en; v.ud = ud;
    v.exp_cnt = ec; v.exp_tc = et; v.name = nm;
    vecs.push_back(v);
  endtask

  // Behavioural reference: modular arithmetic on an integer, following the operation rules.
  task automatic model_step(input bit r, input bit ld, input int lv, input bit en, input bit ud);
    if (!r) begin
      m_cnt = 0; m_tc = 0;
    end else if (ld) begin
      m_cnt = (lv > MAX) ? MAX : lv; m_tc = 0;
    end else if (en) begin
      if (ud) begin
        m_tc = (m_cnt == MAX) ? 1 : 0;
`ifdef IIITB_PUDC_SAT_EN
        m_cnt = (m_cnt < MAX) ? m_cnt + 1 : MAX;
`else
        m_cnt = (m_cnt + 1) % (MAX + 1);
`endif
      end else begin
        m_tc = (m_cnt == 0) ? 1 : 0;
`ifdef IIITB_PUDC_SAT_EN
        m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
`else
        m_cnt = (m_cnt + MAX) % (MAX + 1);
`endif
      end
    end else begin
      m_tc = 0;
    end
  endtask

  // Drive one cycle of inputs, clock it, and advance the model.
  task automatic apply(input bit r, input bit ld, input int lv, input bit en, input bit ud);
    reset = r; Load = ld; LoadVal = W'(lv); En = en; UpOrDown = ud;
    model_step(r, ld, lv, en, ud);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; Load = 1'b0; LoadVal = '0; En = 1'b0; UpOrDown = 1'b1;
    #1;

    // Reset scenario
    add(0, 0, 0, 0, 1, 0, 0, "reset_init");
    add(1, 1, 5, 1, 1, 5, 0, "load5");
    add(0, 0, 0, 1, 1, 0, 0, "reset_mid1");
    add(0, 0, 0, 1, 1, 0, 0, "reset_mid2");
    // Up count across the boundary
    for (int i = 1; i <= 9; i++) add(1, 0, 0, 1, 1, i, 0, "up_run");
`ifdef IIITB_PUDC_SAT_EN
    add(1, 0, 0, 1, 1, 9, 1, "up_sat1");
    add(1, 0, 0, 1, 1, 9, 1, "up_sat2");
    add(1, 0, 0, 1, 1, 9, 1, "up_sat3");
`else
    add(1, 0, 0, 1, 1, 0, 1, "up_wrap");
    add(1, 0, 0, 1, 1, 1, 0, "up_after1");
    add(1, 0, 0, 1, 1, 2, 0, "up_after2");
`endif
    // Down count across zero
    add(1, 1, 2, 0, 0, 2, 0, "load2");
    add(1, 0, 0, 1, 0, 1, 0, "down1");
    add(1, 0, 0, 1, 0, 0, 0, "down0");
`ifdef IIITB_PUDC_SAT_EN
    add(1, 0, 0, 1, 0, 0, 1, "down_sat1");
    add(1, 0, 0, 1, 0, 0, 1, "down_sat2");
`else
    add(1, 0, 0, 1, 0, 9, 1, "down_wrap");
    add(1, 0, 0, 1, 0, 8, 0, "down_after");
`endif
    // Load priority, clamp, hold and direction change
    add(1, 1, 13, 1, 1, 9, 0, "load_clamp");
    add(1, 1, 4, 0, 1, 4, 0, "load4");
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 1, 4, 0, "hold");
    add(1, 0, 0, 1, 1, 5, 0, "dir_up");
    add(1, 0, 0, 1, 0, 4, 0, "dir_down");
    add(1, 0, 0, 1, 1, 5, 0, "dir_up2");
    // Boundary from load 8
    add(1, 1, 8, 0, 1, 8, 0, "load8");
    add(1, 0, 0, 1, 1, 9, 0, "b_up1");
`ifdef IIITB_PUDC_SAT_EN
    add(1, 0, 0, 1, 1, 9, 1, "b_up2");
    add(1, 0, 0, 1, 1, 9, 1, "b_up3");
    add(1, 1, 0, 0, 0, 0, 0, "load0");
    add(1, 0, 0, 1, 0, 0, 1, "b_down");
`else
    add(1, 0, 0, 1, 1, 0, 1, "b_up2");
    add(1, 0, 0, 1, 1, 1, 0, "b_up3");
    add(1, 1, 0, 0, 0, 0, 0, "load0");
    add(1, 0, 0, 1, 0, 9, 1, "b_down");
`endif
    add(1, 1, 15, 0, 0, 9, 0, "load_clamp15");
    add(0, 1, 3, 1, 1, 0, 0, "reset_over_load");

    foreach (vecs[i]) begin
      apply(vecs[i].rst_n, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ud);
      chk({vecs[i].name, "_count"}, 32'(Count), 32'(vecs[i].exp_cnt));
      chk({vecs[i].name, "_tc"},    32'(Tc),    32'(vecs[i].exp_tc));
    end

    // Randomized phase against the reference model; bias towards enable to hit boundaries.
    for (int n = 0; n < 400; n++) begin
      bit r, ld, en, ud;
      int lv;
      r  = ($urandom_range(0, 29) != 0);
      ld = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 3) != 0);
      ud = ($urandom_range(0, 9) < 6);
      lv = $urandom_range(0, 15);
      apply(r, ld, lv, en, ud);
      chk("rand_count", 32'(Count), 32'(m_cnt));
      chk("rand_tc",    32'(Tc),    32'(m_tc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iiitb_pudc.md
# iiitb_pudc

Parametrised up/down modulo counter: the next generation of the team's 4-bit up/down counter, generalised to any width and modulus. It adds count enable, synchronous parallel load and a registered terminal-count pulse. It sits as a leaf timing/sequencing block and can drive dividers, decade displays or slot counters. Wrap-around is the default behaviour; saturation is available as a build option.

## Interface
Parameters:
- WIDTH, 4, counter width in bits; must be at least 1.
- MAX_COUNT, 2**WIDTH-1, highest count value, which sets the modulus to MAX_COUNT+1. Legal range is 1 to 2**WIDTH-1. Elaboration fails outside this range.

Ports:
- Clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset: sampled on the Clk rising edge, asserted when 0.
- En  input  1  count enable; when high, one step per cycle.
- Load  input  1  synchronous parallel load.
- LoadVal  input  WIDTH  value to load.
- UpOrDown  input  1  direction: 1 = up, 0 = down.
- Count  output  WIDTH  registered count value.
- Tc  output  1  registered terminal-count pulse.

## Operation
- Priority, highest first: reset, then Load, then En, then hold.
- Reset (reset=0 at a Clk edge):
  - Count <= 0 and Tc <= 0.
  - Applies mid-count and mid-load; all other inputs are ignored that cycle.
- Load=1:
  - Count <= LoadVal when LoadVal <= MAX_COUNT; otherwise Count <= MAX_COUNT (clamp).
  - Tc <= 0. En and UpOrDown are ignored.
- En=1, Load=0, UpOrDown=1:
  - Count < MAX_COUNT: Count <= Count+1, Tc <= 0.
  - Count == MAX_COUNT: Count <= 0 (wrap), Tc <= 1.
- En=1, Load=0, UpOrDown=0:
  - Count > 0: Count <= Count-1, Tc <= 0.
  - Count == 0: Count <= MAX_COUNT (wrap), Tc <= 1.
- En=0, Load=0: Count holds and Tc <= 0.
- Arithmetic:
  - Increment and decrement are WIDTH-bit, and boundaries are compared against MAX_COUNT, not 2**WIDTH-1.
  - Count never takes a value above MAX_COUNT.
- UpOrDown may change on any cycle; the new direction applies to the next enabled step.

## Timing
- Step latency is one cycle: the inputs at edge N determine Count after edge N.
- Tc is high for exactly one cycle, the same cycle in which Count first shows the wrapped (or saturated) value.
  - Continuous counting at the boundary gives one Tc pulse per boundary crossing.
- Load latency is one cycle.
- Reset takes effect at the first Clk edge with reset=0. Count=0 and Tc=0 are visible after that edge.
- No combinational path exists from inputs to outputs.

## Configuration
- Macro: IIITB_PUDC_SAT_EN.
- Defined (saturating mode):
  - Up at MAX_COUNT holds MAX_COUNT and Tc <= 1.
  - Down at 0 holds 0 and Tc <= 1.
  - Tc then repeats every enabled cycle while Count is pinned at the boundary in that direction.
- Undefined: wrap behaviour as described in Operation.
- Load, reset and hold behaviour are identical in both builds.

## Structure
- Package iiitb_pudc_pkg contains:
  - direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0;
  - a function computing the default MAX_COUNT from WIDTH.
- One sub-module, iiitb_pudc_next:
  - combinational next-count and boundary-detect logic, parametrised on WIDTH/MAX_COUNT and the saturation build option;
  - the top level holds only the Count and Tc registers and the priority mux.

## Test plan
All scenarios use WIDTH=4 and MAX_COUNT=9 unless stated otherwise.
- Reset: reset=0 for 2 cycles while En=1 from Count=5 -> Count=0 and Tc=0 after the first edge, and Count stays 0 while reset is held.
- Up wrap: reset, then En=1, UpOrDown=1 for 12 cycles -> Count runs 1..9, 0, 1, 2; Tc is high only in the cycle Count=0.
- Down wrap: Load 2, then En=1, UpOrDown=0 for 4 cycles -> Count runs 1, 0, 9, 8; Tc is high only in the cycle Count first reads 9.
- Load priority and clamp:
  - Load=1, LoadVal=13 with En=1 -> Count=9 and Tc=0.
  - Next cycle, Load=1, LoadVal=4 -> Count=4.
- Hold and direction change: En=0 for 3 cycles at Count=4 -> Count stays 4. Then En=1 alternating UpOrDown 1, 0, 1 -> Count runs 5, 4, 5.
- Saturation build (IIITB_PUDC_SAT_EN): Load 8, then En=1 up for 3 cycles -> Count runs 9, 9, 9 with Tc running 0, 1, 1. Then down from Load 0 -> Count stays 0 and Tc=1.
